// File: rtl/cache_sched_pkg.sv
// Shared constants for the cache miss memory scheduler.
// FSM encodings, requester IDs and timeout counter width.
package cache_sched_pkg;

    localparam int CNT_W = 8;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

endpackage

// File: rtl/cache_mem_scheduler_if.sv
// Shared memory port: one transaction, completed by mem_ready.
// The scheduler is the master; the memory is the slave.
interface cache_mem_scheduler_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_we, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_we, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/cache_req_slot.sv
// One outstanding request per requester: pending bit plus fields.
// A grant frees the slot, so a same-cycle request refills it.
module cache_req_slot #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              pending_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              we_o,
    output logic [DATA_W-1:0] wdata_o
);

    logic              pending_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
        end else if (set_i && (!pending_q || clr_i)) begin
            pending_q <= 1'b1;
            addr_q    <= addr_i;
            we_q      <= we_i;
            wdata_q   <= wdata_i;
        end else if (clr_i) begin
            pending_q <= 1'b0;
        end
    end

    assign pending_o = pending_q;
    assign addr_o    = addr_q;
    assign we_o      = we_q;
    assign wdata_o   = wdata_q;

endmodule

// File: rtl/cache_mem_scheduler.sv
// Round-robin sequencer of I-cache and D-cache misses onto one
// memory port, with a bounded wait and per-side done pulses.
module cache_mem_scheduler
    import cache_sched_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_done,
    input  logic                  d_req,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic                  d_we,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_done,
    output logic [DATA_W-1:0]     rdata,
    output logic                  busy,
    output logic                  timeout_err,
    cache_mem_scheduler_if.master mem
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic              i_pend, d_pend, i_clr, d_clr;
    logic [ADDR_W-1:0] i_sa, d_sa;
    logic              i_swe, d_swe;
    logic [DATA_W-1:0] i_swd, d_swd;
    logic              grant, side;

    logic [1:0]        state_q, state_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              last_q, last_d;
    logic              side_q, side_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              idone_q, idone_d;
    logic              ddone_q, ddone_d;
    logic              tmo_q, tmo_d;

    cache_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_i_slot (
        .clk, .reset,
        .set_i(i_req), .clr_i(i_clr),
        .addr_i(i_addr), .we_i(1'b0), .wdata_i('0),
        .pending_o(i_pend), .addr_o(i_sa),
        .we_o(i_swe), .wdata_o(i_swd)
    );

    cache_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_d_slot (
        .clk, .reset,
        .set_i(d_req), .clr_i(d_clr),
        .addr_i(d_addr), .we_i(d_we), .wdata_i(d_wdata),
        .pending_o(d_pend), .addr_o(d_sa),
        .we_o(d_swe), .wdata_o(d_swd)
    );

    // On a tie, serve the side that did not win last time.
    assign side  = (i_pend && d_pend) ? ~last_q : d_pend;
    assign grant = (state_q == IDLE) && (i_pend || d_pend);
    assign i_clr = grant && (side == REQ_I);
    assign d_clr = grant && (side == REQ_D);

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        last_d  = last_q;
        side_d  = side_q;
        cnt_d   = cnt_q;
        idone_d = 1'b0;
        ddone_d = 1'b0;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = ISSUE;
                    valid_d = 1'b1;
                    addr_d  = (side == REQ_D) ? d_sa : i_sa;
                    we_d    = (side == REQ_D) ? d_swe : i_swe;
                    wdata_d = (side == REQ_D) ? d_swd : i_swd;
                    last_d  = side;
                    side_d  = side;
                    cnt_d   = '0;
                end
            end
            ISSUE: begin
                if (mem.mem_ready || cnt_q == LAST) begin
                    state_d = RESP;
                    valid_d = 1'b0;
                    idone_d = (side_q == REQ_I);
                    ddone_d = (side_q == REQ_D);
                    if (!mem.mem_ready) begin
                        rdata_d = '0;
                        tmo_d   = 1'b1;
                    end else if (!we_q) begin
                        rdata_d = mem.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            last_q  <= REQ_D;
            side_q  <= REQ_I;
            cnt_q   <= '0;
            idone_q <= 1'b0;
            ddone_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            last_q  <= last_d;
            side_q  <= side_d;
            cnt_q   <= cnt_d;
            idone_q <= idone_d;
            ddone_q <= ddone_d;
            tmo_q   <= tmo_d;
        end
    end

    assign mem.mem_valid = valid_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_wdata = wdata_q;
    assign rdata         = rdata_q;
    assign i_done        = idone_q;
    assign d_done        = ddone_q;
    assign timeout_err   = tmo_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_cache_mem_scheduler.sv
// Cycle-table bench for cache_mem_scheduler (TIMEOUT=4),
// plus directed timeout and reset-during-issue sequences.
module tb_cache_mem_scheduler;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        idone;
        logic        ddone;
        logic [31:0] rdata;
        logic        tmo;
        logic        busy;
    } out_t;

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic [31:0] daddr;
        logic        dwe;
        logic [31:0] dwd;
        logic        rdy;
        logic [31:0] rdat;
        out_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_done, d_done, busy, timeout_err;
    logic [31:0] rdata;

    int n_chk  = 0;
    int n_fail = 0;

    vec_t vq[$];

    cache_mem_scheduler_if #(.ADDR_W(32), .DATA_W(32)) mem ();

    cache_mem_scheduler #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(4)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we),
        .d_wdata(d_wdata), .d_done(d_done),
        .rdata(rdata), .busy(busy), .timeout_err(timeout_err),
        .mem(mem)
    );

    always #5 clk = ~clk;

    function automatic out_t o(
        input logic [31:0] v, a, w, wd, id, dd, rd, t, b
    );
        out_t r;
        r.valid = v[0];
        r.addr  = a;
        r.we    = w[0];
        r.wdata = wd;
        r.idone = id[0];
        r.ddone = dd[0];
        r.rdata = rd;
        r.tmo   = t[0];
        r.busy  = b[0];
        return r;
    endfunction

    function automatic vec_t mk(
        input logic [31:0] rs, ir, ia, dr, da, dw, wd, rdy, rd,
        input out_t e
    );
        vec_t r;
        r.rst   = rs[0];
        r.ireq  = ir[0];
        r.iaddr = ia;
        r.dreq  = dr[0];
        r.daddr = da;
        r.dwe   = dw[0];
        r.dwd   = wd;
        r.rdy   = rdy[0];
        r.rdat  = rd;
        r.exp   = e;
        return r;
    endfunction

    function automatic out_t act();
        out_t r;
        r.valid = mem.mem_valid;
        r.addr  = mem.mem_addr;
        r.we    = mem.mem_we;
        r.wdata = mem.mem_wdata;
        r.idone = i_done;
        r.ddone = d_done;
        r.rdata = rdata;
        r.tmo   = timeout_err;
        r.busy  = busy;
        return r;
    endfunction

    task automatic idle_in();
        reset = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_addr = '0;
        d_we = 1'b0; d_wdata = '0;
        mem.mem_ready = 1'b0; mem.mem_rdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] a, e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    initial begin
        int vcnt;
        logic seen, addr_ok;
        out_t a;

        idle_in();
        reset = 1'b1;

        // rst ir ia dr da dw wd rdy rd | v addr we wd id dd rdata tmo busy
        vq.push_back(mk(1,0,0,0,0,0,0,0,0, o(0,0,0,0,0,0,0,0,0)));
        // single read; mem_ready while idle is ignored
        vq.push_back(mk(0,0,0,1,'h100,0,0,1,'hBAD, o(0,0,0,0,0,0,0,0,0)));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0, o(1,'h100,0,0,0,0,0,0,1)));
        vq.push_back(mk(0,0,0,0,0,0,0,1,'hDEADBEEF,
                        o(0,'h100,0,0,0,1,'hDEADBEEF,0,1)));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0, o(0,'h100,0,0,0,0,'hDEADBEEF,0,0)));
        // tie then round-robin I, D, I, D
        vq.push_back(mk(0,1,'h200,1,'h300,0,0,0,0,
                        o(0,'h100,0,0,0,0,'hDEADBEEF,0,0)));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0, o(1,'h200,0,0,0,0,'hDEADBEEF,0,1)));
        vq.push_back(mk(0,1,'h400,0,0,0,0,1,'h11111111,
                        o(0,'h200,0,0,1,0,'h11111111,0,1)));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0, o(0,'h200,0,0,0,0,'h11111111,0,0)));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0, o(1,'h300,0,0,0,0,'h11111111,0,1)));
        vq.push_back(mk(0,0,0,1,'h500,0,0,1,'h22222222,
                        o(0,'h300,0,0,0,1,'h22222222,0,1)));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0, o(0,'h300,0,0,0,0,'h22222222,0,0)));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0, o(1,'h400,0,0,0,0,'h22222222,0,1)));
        vq.push_back(mk(0,0,0,0,0,0,0,1,'h33333333,
                        o(0,'h400,0,0,1,0,'h33333333,0,1)));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0, o(0,'h400,0,0,0,0,'h33333333,0,0)));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0, o(1,'h500,0,0,0,0,'h33333333,0,1)));
        vq.push_back(mk(0,0,0,0,0,0,0,1,'h44444444,
                        o(0,'h500,0,0,0,1,'h44444444,0,1)));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0, o(0,'h500,0,0,0,0,'h44444444,0,0)));
        // write keeps rdata
        vq.push_back(mk(0,0,0,1,'h700,1,'h55,0,0,
                        o(0,'h500,0,0,0,0,'h44444444,0,0)));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0, o(1,'h700,1,'h55,0,0,'h44444444,0,1)));
        vq.push_back(mk(0,0,0,0,0,0,0,1,'hFFFFFFFF,
                        o(0,'h700,1,'h55,0,1,'h44444444,0,1)));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0, o(0,'h700,1,'h55,0,0,'h44444444,0,0)));
        // duplicate d_req while pending is dropped
        vq.push_back(mk(0,1,'h800,1,'h10,0,0,0,0,
                        o(0,'h700,1,'h55,0,0,'h44444444,0,0)));
        vq.push_back(mk(0,0,0,1,'h20,0,0,0,0, o(1,'h800,0,0,0,0,'h44444444,0,1)));
        vq.push_back(mk(0,0,0,0,0,0,0,1,'h66, o(0,'h800,0,0,1,0,'h66,0,1)));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0, o(0,'h800,0,0,0,0,'h66,0,0)));
        vq.push_back(mk(0,0,0,1,'h30,0,0,0,0, o(1,'h10,0,0,0,0,'h66,0,1)));
        vq.push_back(mk(0,0,0,0,0,0,0,1,'h77, o(0,'h10,0,0,0,1,'h77,0,1)));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0, o(0,'h10,0,0,0,0,'h77,0,0)));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0, o(1,'h30,0,0,0,0,'h77,0,1)));
        vq.push_back(mk(0,0,0,0,0,0,0,1,'h88, o(0,'h30,0,0,0,1,'h88,0,1)));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0, o(0,'h30,0,0,0,0,'h88,0,0)));

        foreach (vq[i]) begin
            reset = vq[i].rst;
            i_req = vq[i].ireq; i_addr = vq[i].iaddr;
            d_req = vq[i].dreq; d_addr = vq[i].daddr;
            d_we = vq[i].dwe; d_wdata = vq[i].dwd;
            mem.mem_ready = vq[i].rdy; mem.mem_rdata = vq[i].rdat;
            step();
            a = act();
            n_chk++;
            if (a !== vq[i].exp) begin
                n_fail++;
                $display("FAIL vec%0d: got %h expected %h",
                         i, a, vq[i].exp);
            end
        end

        // stall until timeout
        idle_in();
        i_req = 1'b1; i_addr = 32'h600;
        step();
        idle_in();
        vcnt = 0; seen = 1'b0; addr_ok = 1'b1;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (mem.mem_valid) begin
                vcnt++;
                if (mem.mem_addr !== 32'h600) addr_ok = 1'b0;
            end
            if (i_done) begin
                seen = 1'b1;
                chk("to_err", {31'd0, timeout_err}, 32'd1);
                chk("to_rdata", rdata, 32'd0);
                chk("to_ddone", {31'd0, d_done}, 32'd0);
            end
        end
        chk("to_done_seen", {31'd0, seen}, 32'd1);
        chk("to_valid_cycles", vcnt, 32'd4);
        chk("to_addr_stable", {31'd0, addr_ok}, 32'd1);
        step();
        chk("to_err_pulse", {31'd0, timeout_err}, 32'd0);
        chk("to_idle", {31'd0, busy}, 32'd0);

        // reset during ISSUE
        i_req = 1'b1; i_addr = 32'h900;
        d_req = 1'b1; d_addr = 32'h910;
        step();
        idle_in();
        step();
        chk("rs_valid", {31'd0, mem.mem_valid}, 32'd1);
        chk("rs_addr", mem.mem_addr, 32'h910);
        reset = 1'b1;
        step();
        chk("rs_valid0", {31'd0, mem.mem_valid}, 32'd0);
        chk("rs_busy0", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        mem.mem_ready = 1'b1; mem.mem_rdata = 32'hABCD;
        step();
        chk("rs_nodone", {30'd0, i_done, d_done}, 32'd0);
        chk("rs_rdata", rdata, 32'd0);
        idle_in();
        vcnt = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (mem.mem_valid || i_done || d_done) vcnt++;
        end
        chk("rs_slots_clear", vcnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_mem_scheduler.md
# cache_mem_scheduler

Sequences the single shared memory port between the instruction-cache and data-cache miss paths. It captures one outstanding request per requester and arbitrates round-robin when both are pending. It drives one memory transaction at a time, with a bounded wait, and returns read data plus a one-cycle completion pulse to the requester it served. It sits between the cache miss queues, whose pop is driven by the completion pulse, and the memory interface.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum cycles in ISSUE before abort; 8-bit counter, TIMEOUT ≥ 1
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- i_req  in  1  instruction-side request pulse
- i_addr  in  ADDR_W  sampled when i_req=1
- i_done  out  1  one-cycle completion pulse for instruction side
- d_req  in  1  data-side request pulse
- d_addr  in  ADDR_W  sampled when d_req=1
- d_we  in  1  write enable, sampled when d_req=1
- d_wdata  in  DATA_W  sampled when d_req=1
- d_done  out  1  one-cycle completion pulse for data side
- rdata  out  DATA_W  read data of last completed transaction, held until next completion
- mem_valid  out  1  transaction request to memory
- mem_addr  out  ADDR_W  transaction address
- mem_we  out  1  transaction write enable; always 0 for instruction side
- mem_wdata  out  DATA_W  transaction write data
- mem_ready  in  1  memory accepts and completes in the same cycle
- mem_rdata  in  DATA_W  valid when mem_ready=1
- busy  out  1  state ≠ IDLE
- timeout_err  out  1  one-cycle pulse, coincident with the done of an aborted transaction

## Operation
- Per-requester slot: pending bit plus captured addr, we and wdata.
  - A req pulse with pending=0 sets pending next cycle and captures the fields.
  - A req pulse with pending=1 is ignored: fields are not overwritten and no error is raised.
- Slot clears on the cycle its request is granted. A new req in that same cycle is accepted, so the slot is refilled.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: no slot pending → stay. One pending → grant it. Both pending → grant the side opposite last_grant. On grant: latch the slot into the mem_* registers, update last_grant, clear the counter, go to ISSUE.
  - ISSUE: mem_valid=1.
    - mem_ready=1 → capture mem_rdata into rdata (reads only; writes leave rdata unchanged), go to RESP.
    - Otherwise, counter == TIMEOUT-1 → set rdata=0, go to RESP with timeout_err flagged.
    - Otherwise increment the counter.
  - RESP: pulse the granted side's done, and timeout_err if flagged, then go to IDLE.
- Reset value of last_grant is "data", so the first tie goes to the instruction side.
- All outputs are registered. Reset values: all 0, state IDLE, both slots empty, rdata 0.

## Timing
- Best-case latency: req at cycle 0 → pending at 1 → grant, ISSUE at 2 with mem_valid=1 → mem_ready at 2 → done at 3 → IDLE at 4.
- Back-to-back: with the other slot pending, its ISSUE starts 2 cycles after the previous done.
- mem_addr, mem_we and mem_wdata are stable for the whole of ISSUE. mem_valid drops the cycle after mem_ready.
- mem_ready outside ISSUE is ignored.
- Timeout: mem_valid is high for exactly TIMEOUT cycles, then done and timeout_err are asserted together.
- A req for the side in flight during ISSUE or RESP is captured and served later; the in-flight transaction is unaffected.
- Reset mid-ISSUE: mem_valid=0 the next cycle, no done is issued, both slots are cleared, and the late mem_ready is ignored.

## Structure
- Package cache_sched_pkg holds:
  - the state enum {IDLE, ISSUE, RESP}
  - requester IDs REQ_I=0, REQ_D=1
  - the TIMEOUT counter width constant
- Sub-module cache_req_slot (pending bit plus captured fields, with set/clear rules) is instantiated twice. The instruction-side instance has we and wdata tied to 0.

## Test plan
- Single read: d_req with d_addr=0x100 at cycle 0, mem_ready=1 at first ISSUE cycle with mem_rdata=0xDEADBEEF → mem_addr=0x100 at cycle 2, d_done=1 and rdata=0xDEADBEEF at cycle 3.
- Tie and round-robin: i_req and d_req in the same cycle, twice in a row → grant order I, D, I, D; no done overlap.
- Stall and timeout: TIMEOUT=4, mem_ready held 0 → mem_valid high for 4 cycles, then i_done=1 and timeout_err=1 with rdata=0.
- Duplicate req: d_req with addr 0x10, then d_req with 0x20 while still pending → only 0x10 is issued; after grant a third d_req with 0x30 is issued next.
- Write: d_req with d_we=1 and d_wdata=0x55 → mem_we=1 and mem_wdata=0x55 in ISSUE, d_done pulses, rdata keeps its previous value.
- Reset in ISSUE: assert reset while mem_valid=1 → mem_valid=0 and busy=0 next cycle, no done pulse even if mem_ready follows.
